// File: rtl/seg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seg_pkg : shared types, constants and index-width helper for seg_scan_ctrl |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package seg_pkg;

  localparam int         NIBBLE_W = 4;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  typedef logic [NIBBLE_W-1:0] nibble_t;
  typedef logic [6:0]          seg_t;

  // Width of a digit index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seven_seg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seven_seg : hex nibble to active-low seven-segment pattern (g..a)          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module seven_seg
  import seg_pkg::*;
(
  input  logic [NIBBLE_W-1:0] i_nibble,
  output logic [6:0]          o_seg
);

  always_comb begin
    o_seg = SEG_OFF;
    case (i_nibble)
      4'h0: o_seg = 7'h40;
      4'h1: o_seg = 7'h79;
      4'h2: o_seg = 7'h24;
      4'h3: o_seg = 7'h30;
      4'h4: o_seg = 7'h19;
      4'h5: o_seg = 7'h12;
      4'h6: o_seg = 7'h02;
      4'h7: o_seg = 7'h78;
      4'h8: o_seg = 7'h00;
      4'h9: o_seg = 7'h10;
      4'hA: o_seg = 7'h08;
      4'hB: o_seg = 7'h03;
      4'hC: o_seg = 7'h46;
      4'hD: o_seg = 7'h21;
      4'hE: o_seg = 7'h06;
      4'hF: o_seg = 7'h0E;
      default: o_seg = SEG_OFF;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seg_scan_ctrl : multiplexed seven-segment scanner with frame-aligned load  |
// | Option macro SEG_LEADING_ZERO_BLANK_EN suppresses leading zero digits.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         load,
  input  logic [NIBBLE_W*DIGITS-1:0]   value,
  input  logic                         blank,
  output logic                         ack,
  output logic [6:0]                   seg,
  output logic [DIGITS-1:0]            an
);

  localparam int DW = NIBBLE_W * DIGITS;
  localparam int IW = idx_width(DIGITS);
  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] c_presc_max = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] c_idx_max   = IW'(DIGITS - 1);

  logic [PW-1:0]     r_presc;
  logic [IW-1:0]     r_idx;
  logic              r_pend;
  logic [DW-1:0]     r_pend_val;
  logic [DW-1:0]     r_disp;
  logic              r_ack;
  logic [6:0]        r_seg;
  logic [DIGITS-1:0] r_an;

  logic              w_tick;
  logic              w_frame;
  logic              w_commit;
  logic              w_show;
  nibble_t           w_nibble;
  seg_t              w_seg_dec;
  logic [DIGITS-1:0] w_an_sel;

  assign w_tick   = (r_presc == c_presc_max);
  assign w_frame  = w_tick && (r_idx == c_idx_max);
  assign w_commit = w_frame && (load || r_pend);

  always_comb begin
    w_nibble = r_disp[NIBBLE_W-1:0];
    w_an_sel = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == IW'(i)) begin
        w_nibble    = r_disp[i*NIBBLE_W +: NIBBLE_W];
        w_an_sel[i] = 1'b0;
      end
    end
  end

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic [IW-1:0] w_msd;

  // Highest non-zero digit; stays 0 for an all-zero display so digit 0 shows.
  always_comb begin
    w_msd = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_disp[i*NIBBLE_W +: NIBBLE_W] != '0) w_msd = IW'(i);
    end
  end

  assign w_show = (r_idx <= w_msd);
`else
  assign w_show = 1'b1;
`endif

  seven_seg u_seven_seg (
    .i_nibble (w_nibble),
    .o_seg    (w_seg_dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc    <= '0;
      r_idx      <= '0;
      r_pend     <= 1'b0;
      r_pend_val <= '0;
      r_disp     <= '0;
      r_ack      <= 1'b0;
      r_seg      <= SEG_OFF;
      r_an       <= '1;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) r_idx <= (r_idx == c_idx_max) ? '0 : r_idx + 1'b1;

      r_ack <= w_commit;
      if (w_commit) begin
        // A load coinciding with the boundary bypasses the pending register.
        r_disp <= load ? value : r_pend_val;
        r_pend <= 1'b0;
      end else if (load) begin
        r_pend_val <= value;
        r_pend     <= 1'b1;
      end

      // The cycle after a tick is dead time while the index settles.
      if (w_tick || blank || !w_show) begin
        r_an  <= '1;
        r_seg <= SEG_OFF;
      end else begin
        r_an  <= w_an_sel;
        r_seg <= w_seg_dec;
      end
    end
  end

  assign ack = r_ack;
  assign seg = r_seg;
  assign an  = r_an;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_seg_scan_ctrl : scoreboard bench for seg_scan_ctrl (DIGITS=4,PRESCALE=4) |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_seg_scan_ctrl;

  localparam int DIGITS   = 4;
  localparam int PRESCALE = 4;
  localparam int FRAME    = DIGITS * PRESCALE;

  typedef struct {
    int          frame;
    logic [15:0] val;
  } commit_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        load  = 1'b0;
  logic        blank = 1'b0;
  logic [15:0] value = '0;
  logic        ack;
  logic [6:0]  seg;
  logic [3:0]  an;

  int          checks   = 0;
  int          failures = 0;
  int          cyc;
  commit_t     sb_q[$];
  logic [15:0] m_disp = '0;

  seg_scan_ctrl #(.DIGITS(DIGITS), .PRESCALE(PRESCALE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .value (value),
    .blank (blank),
    .ack   (ack),
    .seg   (seg),
    .an    (an)
  );

  always #5 clk = ~clk;

  // Edges seen since reset release; cycle c lies between edge c and edge c+1.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [3:0] exp_an(input int c, input logic [15:0] d, input bit blk);
    int idx;
    if (blk || (c % PRESCALE) == 0) return 4'hF;
    idx = (c / PRESCALE) % DIGITS;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    begin
      int msd;
      msd = 0;
      for (int i = 0; i < DIGITS; i++) if (d[i*4 +: 4] != 4'h0) msd = i;
      if (idx > msd) return 4'hF;
    end
`endif
    return ~(4'b0001 << idx);
  endfunction

  function automatic logic [6:0] exp_seg(input int c, input logic [15:0] d, input bit blk);
    int idx;
    if (exp_an(c, d, blk) == 4'hF) return 7'h7F;
    idx = (c / PRESCALE) % DIGITS;
    return hex7(d[idx*4 +: 4]);
  endfunction

  // Loads commit at the next frame start; later loads in a frame supersede earlier ones.
  task automatic do_load(input logic [15:0] v);
    commit_t e;
    load    = 1'b1;
    value   = v;
    e.frame = cyc / FRAME + 1;
    e.val   = v;
    sb_q.push_back(e);
  endtask

  task automatic sb_advance(output bit exp_ack);
    commit_t e;
    exp_ack = 1'b0;
    if ((cyc % FRAME) == 0) begin
      while (sb_q.size() > 0 && sb_q[0].frame == cyc / FRAME) begin
        e       = sb_q.pop_front();
        m_disp  = e.val;
        exp_ack = 1'b1;
      end
    end
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    load  = 1'b0;
    blank = 1'b0;
    value = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    m_disp = '0;
    sb_q.delete();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    load  = 1'b1;
    blank = 1'b0;
    value = 16'hFFFF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (an !== 4'hF) begin failures++; $display("FAIL reset_an k=%0d got=%b exp=1111", k, an); end
      checks++;
      if (seg !== 7'h7F) begin failures++; $display("FAIL reset_seg k=%0d got=%h exp=7f", k, seg); end
      checks++;
      if (ack !== 1'b0) begin failures++; $display("FAIL reset_ack k=%0d got=%b exp=0", k, ack); end
    end
    load = 1'b0;
  endtask

  task automatic test_load_commit;
    bit be, ea;
    do_reset();
    for (int k = 0; k < 3 * FRAME; k++) begin
      be   = blank;
      load = 1'b0;
      if (cyc == 0) do_load(16'h1234);
      @(negedge clk);
      sb_advance(ea);
      checks++;
      if (an !== exp_an(cyc, m_disp, be)) begin failures++; $display("FAIL load_commit_an cyc=%0d got=%b exp=%b", cyc, an, exp_an(cyc, m_disp, be)); end
      checks++;
      if (seg !== exp_seg(cyc, m_disp, be)) begin failures++; $display("FAIL load_commit_seg cyc=%0d got=%h exp=%h", cyc, seg, exp_seg(cyc, m_disp, be)); end
      checks++;
      if (ack !== ea) begin failures++; $display("FAIL load_commit_ack cyc=%0d got=%b exp=%b", cyc, ack, ea); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_overwrite;
    bit be, ea;
    int acks;
    acks = 0;
    do_reset();
    for (int k = 0; k < 3 * FRAME; k++) begin
      be   = blank;
      load = 1'b0;
      if (cyc == 3) do_load(16'h1111);
      if (cyc == 9) do_load(16'h2222);
      @(negedge clk);
      sb_advance(ea);
      if (ack === 1'b1) acks++;
      checks++;
      if (an !== exp_an(cyc, m_disp, be)) begin failures++; $display("FAIL overwrite_an cyc=%0d got=%b exp=%b", cyc, an, exp_an(cyc, m_disp, be)); end
      checks++;
      if (seg !== exp_seg(cyc, m_disp, be)) begin failures++; $display("FAIL overwrite_seg cyc=%0d got=%h exp=%h", cyc, seg, exp_seg(cyc, m_disp, be)); end
      checks++;
      if (ack !== ea) begin failures++; $display("FAIL overwrite_ack cyc=%0d got=%b exp=%b", cyc, ack, ea); end
      @(posedge clk); #1;
    end
    checks++;
    if (acks != 1) begin failures++; $display("FAIL overwrite_ack_count got=%0d exp=1", acks); end
  endtask

  task automatic test_back_to_back;
    bit be, ea;
    do_reset();
    for (int k = 0; k < 4 * FRAME; k++) begin
      be   = blank;
      load = 1'b0;
      if (cyc == FRAME - 1)     do_load(16'hABCD);
      if (cyc == 2 * FRAME - 1) do_load(16'h9E07);
      @(negedge clk);
      sb_advance(ea);
      checks++;
      if (an !== exp_an(cyc, m_disp, be)) begin failures++; $display("FAIL coincident_an cyc=%0d got=%b exp=%b", cyc, an, exp_an(cyc, m_disp, be)); end
      checks++;
      if (seg !== exp_seg(cyc, m_disp, be)) begin failures++; $display("FAIL coincident_seg cyc=%0d got=%h exp=%h", cyc, seg, exp_seg(cyc, m_disp, be)); end
      checks++;
      if (ack !== ea) begin failures++; $display("FAIL coincident_ack cyc=%0d got=%b exp=%b", cyc, ack, ea); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_blank;
    bit be, ea;
    do_reset();
    for (int k = 0; k < 3 * FRAME; k++) begin
      be    = blank;
      load  = 1'b0;
      blank = (cyc >= 20 && cyc < 30);
      if (cyc == 0)  do_load(16'h5678);
      if (cyc == 22) do_load(16'hC0F1);
      @(negedge clk);
      sb_advance(ea);
      checks++;
      if (an !== exp_an(cyc, m_disp, be)) begin failures++; $display("FAIL blank_an cyc=%0d got=%b exp=%b", cyc, an, exp_an(cyc, m_disp, be)); end
      checks++;
      if (seg !== exp_seg(cyc, m_disp, be)) begin failures++; $display("FAIL blank_seg cyc=%0d got=%h exp=%h", cyc, seg, exp_seg(cyc, m_disp, be)); end
      checks++;
      if (ack !== ea) begin failures++; $display("FAIL blank_ack cyc=%0d got=%b exp=%b", cyc, ack, ea); end
      @(posedge clk); #1;
    end
    blank = 1'b0;
  endtask

  task automatic test_reset_midframe;
    bit be, ea;
    int acks;
    acks = 0;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      load = 1'b0;
      if (cyc == 2) do_load(16'h1234);
      @(posedge clk); #1;
    end
    load = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (an !== 4'hF) begin failures++; $display("FAIL midreset_an got=%b exp=1111", an); end
    checks++;
    if (seg !== 7'h7F) begin failures++; $display("FAIL midreset_seg got=%h exp=7f", seg); end
    checks++;
    if (ack !== 1'b0) begin failures++; $display("FAIL midreset_ack got=%b exp=0", ack); end
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    m_disp = '0;
    sb_q.delete();
    for (int k = 0; k < 3 * FRAME; k++) begin
      be = blank;
      @(negedge clk);
      sb_advance(ea);
      if (ack === 1'b1) acks++;
      checks++;
      if (an !== exp_an(cyc, m_disp, be)) begin failures++; $display("FAIL midreset_scan_an cyc=%0d got=%b exp=%b", cyc, an, exp_an(cyc, m_disp, be)); end
      checks++;
      if (seg !== exp_seg(cyc, m_disp, be)) begin failures++; $display("FAIL midreset_scan_seg cyc=%0d got=%h exp=%h", cyc, seg, exp_seg(cyc, m_disp, be)); end
      @(posedge clk); #1;
    end
    checks++;
    if (acks != 0) begin failures++; $display("FAIL midreset_ack_count got=%0d exp=0", acks); end
  endtask

  task automatic test_value_0050;
    bit be, ea;
    do_reset();
    for (int k = 0; k < 3 * FRAME; k++) begin
      be   = blank;
      load = 1'b0;
      if (cyc == 5) do_load(16'h0050);
      @(negedge clk);
      sb_advance(ea);
      checks++;
      if (an !== exp_an(cyc, m_disp, be)) begin failures++; $display("FAIL v0050_an cyc=%0d got=%b exp=%b", cyc, an, exp_an(cyc, m_disp, be)); end
      checks++;
      if (seg !== exp_seg(cyc, m_disp, be)) begin failures++; $display("FAIL v0050_seg cyc=%0d got=%h exp=%h", cyc, seg, exp_seg(cyc, m_disp, be)); end
      checks++;
      if (ack !== ea) begin failures++; $display("FAIL v0050_ack cyc=%0d got=%b exp=%b", cyc, ack, ea); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_load_commit();
    test_overwrite();
    test_back_to_back();
    test_blank();
    test_reset_midframe();
    test_value_0050();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter DIGITS, 4, number of multiplexed digits (2..8).
REQ-002 Parameter PRESCALE, 50000, clk cycles per digit slot (>= 2).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 load  input  1  request to capture value.
REQ-006 value  input  4*DIGITS  hex nibbles; nibble 0 = rightmost digit.
REQ-007 blank  input  1  force all digits off while high.
REQ-008 ack  output  1  one-cycle pulse when a captured value is committed to the display.
REQ-009 seg  output  7  active-low segment drive (g..a).
REQ-010 an  output  DIGITS  active-low digit enables; at most one low at any time.

Function
REQ-011 Prescaler counts 0..PRESCALE-1 and wraps; tick is asserted in the cycle where the count equals PRESCALE-1.
REQ-012 Digit index advances on tick and wraps from DIGITS-1 to 0; frame boundary is a tick with index DIGITS-1.
REQ-013 Load with no pending value captures value into the pending register and sets pending.
REQ-014 Load while pending already set overwrites the pending register; only the latest value commits.
REQ-015 At a frame boundary with pending set, the pending register is copied to the display register, pending clears, and ack pulses in the following cycle.
REQ-016 Load in the same cycle as a committing frame boundary commits the new value directly, clears pending, and pulses ack.
REQ-017 Display register changes only at frame boundaries; no torn frames.
REQ-018 Dead time: in the cycle after every tick, an is all ones; the next digit is enabled from the second cycle onward.
REQ-019 seg and an are registered; seg shows the decoded nibble of the current index from the same cycle its an bit goes low.
REQ-020 Blank high drives an all ones and seg 7'h7F from the next cycle; scanning, capture, and commit continue unaffected.
REQ-021 An unused seg value while an is all ones is 7'h7F.

Reset
REQ-022 Reset asynchronously clears the prescaler, index, pending flag, pending register, display register, and ack.
REQ-023 During and after reset, an = all ones and seg = 7'h7F until the first enabled digit slot.
REQ-024 Reset in the middle of a frame discards any pending value with no ack; scanning restarts at index 0 with a full PRESCALE slot.

Configuration
REQ-025 Macro SEG_LEADING_ZERO_BLANK_EN: when defined, digits above the most-significant non-zero nibble of the display register keep their an bit high; digit 0 is always shown.
REQ-026 Without SEG_LEADING_ZERO_BLANK_EN, all DIGITS digits are shown, including zeros.

Structure
REQ-027 Shared package seg_pkg holds NIBBLE_W = 4, SEG_OFF = 7'h7F, and the digit-index width function.
REQ-028 A single sub-module instance, seven_seg, decodes the selected nibble; the controller muxes the nibble and registers its output.

Verification (DIGITS=4, PRESCALE=4)
REQ-029 Reset release, load value=16'h1234 -> ack one cycle after the first frame boundary; slots then show 4,3,2,1 on an=1110,1101,1011,0111, each preceded by one all-ones cycle.
REQ-030 Two loads (16'h1111, then 16'h2222) within one frame -> exactly one ack; display shows 2222 and never 1111.
REQ-031 Load 16'hABCD coincident with a frame-boundary tick -> ack next cycle; the new frame shows the new value.
REQ-032 Blank pulsed high for 10 cycles mid-frame -> an all ones and seg 7'h7F for those cycles; index sequence is unaltered afterwards.
REQ-033 rst_n low mid-frame with a pending load -> outputs at reset values immediately; no ack after release; display 0000, or only digit 0 with SEG_LEADING_ZERO_BLANK_EN.
REQ-034 With SEG_LEADING_ZERO_BLANK_EN, value=16'h0050 -> only digits 0 and 1 are enabled; digits 2 and 3 have an high in every slot.
